reg_file_sb: RTL and testbench

//   Parametrised 2-read/1-write register file for the mini core, generalised in width/depth.

---
 rtl/reg_file_sb.sv | 118 +++++++++++
 tb/tb_reg_file_sb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with per-register busy scoreboard, write-to-read bypass
// and optional hardwired-zero R0. Define REG_FILE_RD_REG_EN for registered read outputs.
module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   ra,
  input  logic [ADDR_W-1:0]   rb,
  output logic [DATA_W-1:0]   rd_a,
  output logic [DATA_W-1:0]   rd_b,
  output logic                valid_a,
  output logic                valid_b,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic                alloc_en,
  input  logic [ADDR_W-1:0]   alloc_addr,
  output logic                alloc_ok,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]             busy_flat;
  logic [1:0][ADDR_W-1:0]          rd_addr;
  logic [1:0][DATA_W-1:0]          rd_data_next;
  logic [1:0]                      rd_valid_next;

  // A busy register may be re-allocated only when its writeback lands this same cycle.
  assign alloc_ok = rst_n && alloc_en && !flush &&
                    (!busy_flat[alloc_addr] || (we && (wa == alloc_addr)));
  assign busy_vec = busy_flat;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if ((ZERO_R0 != 0) && (gi == 0)) begin : g_zero
      assign regs_flat[gi] = '0;
      assign busy_flat[gi] = 1'b0;
    end else begin : g_entry
      logic [DATA_W-1:0] data_reg;
      logic              busy_reg;
      logic              wr_hit;
      logic              alloc_hit;

      assign wr_hit    = we && (wa == ADDR_W'(gi));
      assign alloc_hit = alloc_ok && (alloc_addr == ADDR_W'(gi));

      // Priority: flush clears, then a new allocation wins over a same-cycle writeback.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          busy_reg <= 1'b0;
        end else begin
          if (wr_hit)
            data_reg <= wd;
          if (flush)
            busy_reg <= 1'b0;
          else if (alloc_hit)
            busy_reg <= 1'b1;
          else if (wr_hit)
            busy_reg <= 1'b0;
        end
      end

      assign regs_flat[gi] = data_reg;
      assign busy_flat[gi] = busy_reg;
    end
  end

  assign rd_addr[0] = ra;
  assign rd_addr[1] = rb;

  always_comb begin
    rd_data_next  = '0;
    rd_valid_next = '1;
    for (int p = 0; p < 2; p++) begin
      if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
        rd_data_next[p]  = '0;
        rd_valid_next[p] = 1'b1;
      end else if (we && (wa == rd_addr[p])) begin
        rd_data_next[p]  = wd;
        rd_valid_next[p] = 1'b1;
      end else begin
        rd_data_next[p]  = regs_flat[rd_addr[p]];
        rd_valid_next[p] = !busy_flat[rd_addr[p]];
      end
      if (!rst_n) begin
        rd_data_next[p]  = '0;
        rd_valid_next[p] = 1'b1;
      end
    end
  end

`ifdef REG_FILE_RD_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a    <= '0;
      rd_b    <= '0;
      valid_a <= 1'b1;
      valid_b <= 1'b1;
    end else begin
      rd_a    <= rd_data_next[0];
      rd_b    <= rd_data_next[1];
      valid_a <= rd_valid_next[0];
      valid_b <= rd_valid_next[1];
    end
  end
`else
  assign rd_a    = rd_data_next[0];
  assign rd_b    = rd_data_next[1];
  assign valid_a = rd_valid_next[0];
  assign valid_b = rd_valid_next[1];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (combinational read build); a second instance
// with ZERO_R0=1 shares the stimulus for the hardwired-zero checks.
module tb_reg_file_sb;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 2**ADDR_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [ADDR_W-1:0]   ra, rb, wa, alloc_addr;
  logic                we, alloc_en, flush;
  logic [DATA_W-1:0]   wd;

  logic [DATA_W-1:0]   rd_a, rd_b, rd_a_z, rd_b_z;
  logic                valid_a, valid_b, valid_a_z, valid_b_z;
  logic                alloc_ok, alloc_ok_z;
  logic [NUM_REGS-1:0] busy_vec, busy_vec_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(0)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rd_a(rd_a), .rd_b(rd_b),
    .valid_a(valid_a), .valid_b(valid_b), .we(we), .wa(wa), .wd(wd),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok),
    .flush(flush), .busy_vec(busy_vec)
  );

  reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .rd_a(rd_a_z), .rd_b(rd_b_z),
    .valid_a(valid_a_z), .valid_b(valid_b_z), .we(we), .wa(wa), .wd(wd),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_z),
    .flush(flush), .busy_vec(busy_vec_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[%0t] FAIL %s: got %h expected %h", $time, tag, obs, exp);
    end else begin
      $display("[%0t] ok   %s: %h", $time, tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ra = 0; rb = 0; wa = 0; wd = 0;
    we = 0; alloc_en = 1; alloc_addr = 5; flush = 0;
    #3;
    check("rst_rd_a", rd_a, 16'h0000);
    check("rst_valid_a", valid_a, 1);
    check("rst_busy", busy_vec, 8'h00);
    check("rst_alloc_ok", alloc_ok, 0);
    alloc_en = 0;
    tick();
    rst_n = 1'b1;

    // write bypass, then read from the array
    we = 1; wa = 2; wd = 16'h1234; ra = 2; rb = 2;
    #2;
    check("byp_rd_a", rd_a, 16'h1234);
    check("byp_valid_a", valid_a, 1);
    check("byp_rd_b", rd_b, 16'h1234);
    tick();
    we = 0;
    #2;
    check("arr_rd_a", rd_a, 16'h1234);

    // allocate R4, refuse re-alloc, writeback clears
    alloc_en = 1; alloc_addr = 4; ra = 4;
    #2;
    check("alloc4_ok", alloc_ok, 1);
    tick();
    alloc_en = 0;
    #2;
    check("alloc4_busy", busy_vec, 8'h10);
    check("alloc4_valid_a", valid_a, 0);
    alloc_en = 1;
    #2;
    check("realloc4_refused", alloc_ok, 0);
    tick();
    alloc_en = 0;
    #2;
    check("realloc4_busy", busy_vec, 8'h10);
    we = 1; wa = 4; wd = 16'h00AA;
    #2;
    check("wb4_byp_valid", valid_a, 1);
    check("wb4_byp_rd", rd_a, 16'h00AA);
    tick();
    we = 0;
    #2;
    check("wb4_rd", rd_a, 16'h00AA);
    check("wb4_valid", valid_a, 1);
    check("wb4_busy", busy_vec, 8'h00);

    // same-cycle write and alloc: alloc wins
    we = 1; wa = 6; wd = 16'h5555; alloc_en = 1; alloc_addr = 6; ra = 6;
    #2;
    check("wa6_alloc_ok", alloc_ok, 1);
    tick();
    we = 0; alloc_en = 0;
    #2;
    check("wa6_busy", busy_vec, 8'h40);
    check("wa6_rd", rd_a, 16'h5555);
    check("wa6_valid", valid_a, 0);
    we = 1; wd = 16'h6666; alloc_en = 1;
    #2;
    check("busy6_wb_alloc_ok", alloc_ok, 1);
    tick();
    we = 0; alloc_en = 0;
    #2;
    check("busy6_still", busy_vec, 8'h40);
    check("busy6_rd", rd_a, 16'h6666);
    we = 1;
    tick();
    we = 0;
    #2;
    check("busy6_clear", busy_vec, 8'h00);

    // flush overrides alloc, concurrent write lands
    alloc_en = 1; alloc_addr = 1; tick();
    alloc_addr = 2; tick();
    alloc_addr = 7; tick();
    alloc_en = 0;
    #2;
    check("pre_flush_busy", busy_vec, 8'h86);
    flush = 1; alloc_en = 1; alloc_addr = 3; we = 1; wa = 1; wd = 16'h0101;
    #2;
    check("flush_alloc_ok", alloc_ok, 0);
    tick();
    flush = 0; alloc_en = 0; we = 0; ra = 1; rb = 2;
    #2;
    check("flush_busy", busy_vec, 8'h00);
    check("flush_wr_rd", rd_a, 16'h0101);
    check("flush_keep_rd", rd_b, 16'h1234);

    // R0: normal instance vs hardwired-zero instance
    we = 1; wa = 0; wd = 16'hFFFF; alloc_en = 1; alloc_addr = 0; ra = 0; rb = 2;
    #2;
    check("r0_alloc_ok", alloc_ok, 1);
    check("r0_byp_rd", rd_a, 16'hFFFF);
    check("z_r0_alloc_ok", alloc_ok_z, 1);
    check("z_r0_nobyp_rd", rd_a_z, 16'h0000);
    check("z_r0_valid", valid_a_z, 1);
    tick();
    we = 0; alloc_en = 0;
    #2;
    check("r0_rd", rd_a, 16'hFFFF);
    check("r0_valid", valid_a, 0);
    check("r0_busy", busy_vec, 8'h01);
    check("z_r0_rd", rd_a_z, 16'h0000);
    check("z_r0_valid2", valid_a_z, 1);
    check("z_r0_busy", busy_vec_z, 8'h00);
    check("z_r2_rd", rd_b_z, 16'h1234);

    // reset mid-run
    we = 1; wa = 3; wd = 16'hBEEF; alloc_en = 1; alloc_addr = 5;
    tick();
    we = 0; alloc_en = 0; ra = 3; rb = 5;
    #2;
    check("pre_rst_rd", rd_a, 16'hBEEF);
    check("pre_rst_valid_b", valid_b, 0);
    check("pre_rst_busy", busy_vec, 8'h21);
    rst_n = 1'b0; alloc_en = 1;
    #1;
    check("mid_rst_rd", rd_a, 16'h0000);
    check("mid_rst_valid_b", valid_b, 1);
    check("mid_rst_busy", busy_vec, 8'h00);
    check("mid_rst_alloc_ok", alloc_ok, 0);
    alloc_en = 0;
    tick();
    rst_n = 1'b1;
    #2;
    check("post_rst_rd", rd_a, 16'h0000);
    check("post_rst_busy", busy_vec, 8'h00);
    check("post_rst_valid_b", valid_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
